// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) producing HI/LO.
// Takes N+1 cycles per operation: N shift-add or restoring-divide steps,
// then one fix-up cycle that applies sign correction and writes hi/lo.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   start  begin an operation (ignored while busy)
//   op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   a, b   rs / rt operands; sampled with start
//   flush  abort the in-flight operation; drops a simultaneous start
//   busy   operation in flight
//   done   one-cycle pulse when hi/lo are updated
//   hi/lo  product high/low, or remainder/quotient
module mdu_iter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q;
  logic            neg_q;     // negate product / quotient
  logic            rneg_q;    // negate remainder
  logic            dz_q;      // divide by zero
  logic [N-1:0]    a_q;       // raw dividend, returned as hi on divide by zero
  logic [N-1:0]    dvs_q;     // multiplicand / divisor magnitude
  logic [N:0]      rem_q;     // product high half / partial remainder
  logic [N-1:0]    quo_q;     // multiplier / dividend, shifted out as result bits shift in

  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      mul_sum;
  logic [N:0]      div_shift;
  logic            div_ge;
  logic [N:0]      div_sub;
  logic [2*N-1:0]  prod, prod_fix;
  logic [N-1:0]    q_fix, r_fix;

  always_comb begin
    mag_a     = (!op[0] && a[N-1]) ? -a : a;
    mag_b     = (!op[0] && b[N-1]) ? -b : b;
    // Multiply step: conditional add, then the whole {rem, quo} pair shifts right.
    mul_sum   = {1'b0, rem_q[N-1:0]} + {1'b0, (quo_q[0] ? dvs_q : {N{1'b0}})};
    // Divide step: bring down the next dividend bit and try subtracting.
    div_shift = {rem_q[N-1:0], quo_q[N-1]};
    div_ge    = div_shift >= {1'b0, dvs_q};
    div_sub   = div_shift - {1'b0, dvs_q};
    prod      = {rem_q[N-1:0], quo_q};
    prod_fix  = neg_q ? -prod : prod;
    q_fix     = neg_q ? -quo_q : quo_q;
    r_fix     = rneg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            state_q  <= StRun;
            busy     <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q    <= !op[0] && (a[N-1] ^ b[N-1]);
            rneg_q   <= !op[0] && a[N-1];
            dz_q     <= op[1] && (b == '0);
            a_q      <= a;
            dvs_q    <= mag_b;
            rem_q    <= '0;
            quo_q    <= mag_a;
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
              rem_q <= div_ge ? div_sub : div_shift;
              quo_q <= {quo_q[N-2:0], div_ge};
            end else begin
              rem_q <= {1'b0, mul_sum[N:1]};
              quo_q <= {mul_sum[0], quo_q[N-1:1]};
            end
            if (cnt_q == CW'(N - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div_q) begin
              hi <= prod_fix[2*N-1:N];
              lo <= prod_fix[N-1:0];
            end else if (dz_q) begin
              hi <= a_q;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model from plain 64-bit arithmetic.
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] mh, output logic [31:0] ml);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: begin p = 64'(sa * sb); mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = {32'd0, ma} * {32'd0, mb}; mh = p[63:32]; ml = p[31:0]; end
      default: begin
        if (mb == 0) begin
          mh = ma; ml = 32'hFFFF_FFFF;
        end else if (mop == 2'b10) begin
          q = sa / sb; r = sa % sb;
          mh = 32'(r); ml = 32'(q);
        end else begin
          mh = ma % mb; ml = ma / mb;
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    int k, nbusy;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = $urandom; a = $urandom; b = $urandom;   // must not be re-sampled
    k = 0; nbusy = 0;
    while (!done && k < 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 64'(k), 64'd33);
    check({name, " busy cycles"}, 64'(nbusy), 64'd33);
    check({name, " busy low at done"}, 64'(busy), 64'd0);
  endtask

  logic [31:0] eh, el, prev_hi, prev_lo;
  int ndone;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9] = '{2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    check("no done without start", 64'(ndone), 64'd0);

    // Directed table, each followed by one idle cycle to check done width.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      @(negedge clk);
      check($sformatf("vec%0d done one cycle", i), 64'(done), 64'd0);
    end

    // Back-to-back: start on the cycle done is high.
    run_op("b2b first", 2'b01, 32'd3, 32'd4);
    check("b2b first lo", 64'(lo), 64'd12);
    check("b2b done high at restart", 64'(done), 64'd1);
    run_op("b2b DIVU", 2'b11, 32'd100, 32'd7);
    check("b2b hi", 64'(hi), 64'd2);
    check("b2b lo", 64'(lo), 64'd14);

    // Ignored start while busy, then flush.
    prev_hi = hi; prev_lo = lo;
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    op = 2'b11; a = 32'd77; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy after ignored start", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush hi held", 64'(hi), 64'(prev_hi));
    check("flush lo held", 64'(lo), 64'(prev_lo));
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done || busy) ndone++; end
    check("no activity after flush", 64'(ndone), 64'd0);
    check("hi still held", 64'(hi), 64'(prev_hi));
    // flush with start drops the start.
    op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start with flush dropped", 64'(busy), 64'd0);
    run_op("after flush", 2'b01, 32'd5, 32'd6);
    check("after flush lo", 64'(lo), 64'd30);
    check("after flush hi", 64'(hi), 64'd0);

    // Reset mid-operation.
    @(negedge clk);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check("no done after midreset", 64'(ndone), 64'd0);

    // Randomized against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(ro, ra, rb, eh, el);
      run_op($sformatf("rnd%0d", i), ro, ra, rb);
      check($sformatf("rnd%0d op%0d %h/%h hi", i, ro, ra, rb), 64'(hi), 64'(eh));
      check($sformatf("rnd%0d op%0d %h/%h lo", i, ro, ra, rb), 64'(lo), 64'(el));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
